toggle_pulse_decoder: RTL and testbench

- Receive end of the toggle-signalling scheme: the sending side flips a T flip-flop once per event, and this block recovers one event per level change on tgl_in.
- tgl_in is synchronised into clk and each transition is detected; events are queued in a saturating pending counter and delivered one at a time over a valid/ready handshake.
- Sits between any toggle-flag producer and a pulse-consuming controller or counter.

---
 rtl/toggle_pulse_decoder_if.sv | 16 +
 rtl/toggle_pulse_decoder.sv | 170 +++++++++++++++++
 tb/tb_toggle_pulse_decoder.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/toggle_pulse_decoder_if.sv
// rtl/toggle_pulse_decoder_if.sv - event handshake bundle between decoder and consumer
//
// Signals:
//   evt_valid  decoder -> consumer  at least one event is pending
//   evt_ready  consumer -> decoder  consumer accepts one event this cycle
// Modports:
//   master  decoder side (drives evt_valid)
//   slave   consumer side (drives evt_ready)

interface toggle_pulse_decoder_if;
    logic evt_valid;
    logic evt_ready;

    modport master (output evt_valid, input evt_ready);
    modport slave  (input evt_valid, output evt_ready);
endinterface

// File: rtl/toggle_pulse_decoder.sv
// rtl/toggle_pulse_decoder.sv - toggle-level to queued event decoder with valid/ready delivery
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   tgl_in     toggle level from the sender (0 while sender is in reset)
//   evt        handshake bundle (master): evt_valid out, evt_ready in
//   evt_pulse  registered one-cycle strobe per detected transition (dropped ones included)
//   pending    number of queued, undelivered events (saturates at 2^PEND_W-1)
//   evt_count  total delivered events, wraps modulo 2^CNT_W
//   overflow   sticky flag: a transition was dropped because the queue was full
//   ovf_clr    synchronous clear of overflow (a same-cycle set wins)
//
// Optional build macro: TGL_DEGLITCH_EN
//   When defined, the synchronised level must hold a new value for two
//   consecutive cycles before it is accepted as an edge.

module toggle_pulse_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int PEND_W      = 4,
    parameter int CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tgl_in,
    toggle_pulse_decoder_if.master evt,
    output logic                  evt_pulse,
    output logic [PEND_W-1:0]     pending,
    output logic [CNT_W-1:0]      evt_count,
    output logic                  overflow,
    input  logic                  ovf_clr
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    typedef enum logic [1:0] {IDLE, HOLD, FULL} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    lvl;
    logic                    prev;
    logic                    edge_det;
    logic                    take;
    logic                    ovf_set;
    logic [PEND_W-1:0]       pend_next;

    assign lvl  = sync_q[SYNC_STAGES-1];
    assign take = evt.evt_valid & evt.evt_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tgl_in};
        end
    end

`ifdef TGL_DEGLITCH_EN
    // lvl_d remembers the previous synchronised level; an edge qualifies only
    // once the new level has been seen on two consecutive cycles.
    logic lvl_d;

    assign edge_det = (lvl != prev) && (lvl == lvl_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_d <= 1'b0;
            prev  <= 1'b0;
        end else begin
            lvl_d <= lvl;
            if (edge_det) begin
                prev <= lvl;
            end
        end
    end
`else
    assign edge_det = lvl ^ prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= 1'b0;
        end else begin
            prev <= lvl;
        end
    end
`endif

    // Edge and take in the same cycle cancel, which is also how an edge at
    // PEND_MAX is accepted without overflow when a take frees a slot.
    always_comb begin
        pend_next = pending;
        ovf_set   = 1'b0;
        case ({edge_det, take})
            2'b10: begin
                if (pending == PEND_MAX) begin
                    ovf_set = 1'b1;
                end else begin
                    pend_next = pending + 1'b1;
                end
            end
            2'b01:   pend_next = pending - 1'b1;
            default: pend_next = pending;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= '0;
            evt_count <= '0;
            evt_pulse <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            pending   <= pend_next;
            evt_pulse <= edge_det;
            overflow  <= ovf_set | (overflow & ~ovf_clr);
            if (take) begin
                evt_count <= evt_count + 1'b1;
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM: next state, tracking the occupancy class of the updated counter
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (edge_det) begin
                    state_next = (pend_next == PEND_MAX) ? FULL : HOLD;
                end
            end
            HOLD: begin
                if (pend_next == '0) begin
                    state_next = IDLE;
                end else if (pend_next == PEND_MAX) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (take && !edge_det) begin
                    state_next = (pend_next == '0) ? IDLE : HOLD;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM: outputs; IDLE is exactly pending == 0, so valid never sees evt_ready
    always_comb begin
        evt.evt_valid = (state != IDLE);
    end

    always @(posedge clk) begin
        if (rst_n) begin
            assert ((state == IDLE) == (pending == '0) &&
                    (state == FULL) == (pending == PEND_MAX))
                else $error("state/pending inconsistency: state=%0d pending=%0d", state, pending);
        end
    end

endmodule

// File: tb/tb_toggle_pulse_decoder.sv
// tb/tb_toggle_pulse_decoder.sv - directed self-checking bench for toggle_pulse_decoder

module tb_toggle_pulse_decoder;

    localparam int SYNC_STAGES = 2;
`ifdef TGL_DEGLITCH_EN
    localparam int LAT = SYNC_STAGES + 2;
`else
    localparam int LAT = SYNC_STAGES + 1;
`endif

    logic       clk;
    logic       rst_n;
    logic       tgl_in;
    logic       evt_pulse;
    logic [3:0] pending;
    logic [7:0] evt_count;
    logic       overflow;
    logic       ovf_clr;

    int n_cmp;
    int n_bad;
    int pulses;

    toggle_pulse_decoder_if evt_if ();

    toggle_pulse_decoder #(
        .SYNC_STAGES(SYNC_STAGES),
        .PEND_W     (4),
        .CNT_W      (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tgl_in   (tgl_in),
        .evt      (evt_if.master),
        .evt_pulse(evt_pulse),
        .pending  (pending),
        .evt_count(evt_count),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (evt_pulse) pulses++;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        pulses = 0;
        rst_n  = 1'b0;
        tgl_in = 1'b0;
        ovf_clr = 1'b0;
        evt_if.evt_ready = 1'b0;

        // Reset state
        tick(3);
        check("rst_valid",    {31'd0, evt_if.evt_valid}, 32'd0);
        check("rst_pending",  {28'd0, pending}, 32'd0);
        check("rst_count",    {24'd0, evt_count}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_pulse",    {31'd0, evt_pulse}, 32'd0);
        rst_n = 1'b1;

        // Quiet input: no events
        pulses = 0;
        tick(20);
        check("quiet_pulses",  pulses, 32'd0);
        check("quiet_pending", {28'd0, pending}, 32'd0);
        check("quiet_valid",   {31'd0, evt_if.evt_valid}, 32'd0);

        // Two toggles with consumer stalled, then drain
        tgl_in = 1'b1;
        tick(LAT - 1);
        check("lat_early_pulse", {31'd0, evt_pulse}, 32'd0);
        tick(1);
        check("lat_pulse",   {31'd0, evt_pulse}, 32'd1);
        check("lat_pending", {28'd0, pending}, 32'd1);
        check("lat_valid",   {31'd0, evt_if.evt_valid}, 32'd1);
        tick(1);
        check("pulse_width", {31'd0, evt_pulse}, 32'd0);
        tick(5 - LAT - 1);
        tgl_in = 1'b0;
        tick(LAT);
        check("fall_pulse",   {31'd0, evt_pulse}, 32'd1);
        check("fall_pending", {28'd0, pending}, 32'd2);
        evt_if.evt_ready = 1'b1;
        tick(1);
        check("drain1_pending", {28'd0, pending}, 32'd1);
        tick(1);
        check("drain2_pending", {28'd0, pending}, 32'd0);
        check("drain2_count",   {24'd0, evt_count}, 32'd2);
        check("drain2_valid",   {31'd0, evt_if.evt_valid}, 32'd0);
        evt_if.evt_ready = 1'b0;
        tick(4);

        // Saturation: 17 toggles with consumer stalled
        pulses = 0;
        for (int i = 1; i <= 17; i++) begin
            tgl_in = ~tgl_in;
            tick(4);
            if (i == 15) begin
                check("sat15_pending",  {28'd0, pending}, 32'd15);
                check("sat15_overflow", {31'd0, overflow}, 32'd0);
            end
            if (i == 16) begin
                check("sat16_pending",  {28'd0, pending}, 32'd15);
                check("sat16_overflow", {31'd0, overflow}, 32'd1);
            end
        end
        check("sat_pulses",  pulses, 32'd17);
        check("sat_pending", {28'd0, pending}, 32'd15);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("ovf_cleared", {31'd0, overflow}, 32'd0);

        // Drop and clear in the same cycle: set wins
        tgl_in = ~tgl_in;
        tick(LAT - 1);
        ovf_clr = 1'b1;
        tick(1);
        check("setwins_pulse",    {31'd0, evt_pulse}, 32'd1);
        check("setwins_overflow", {31'd0, overflow}, 32'd1);
        check("setwins_pending",  {28'd0, pending}, 32'd15);
        ovf_clr = 1'b0;
        tick(1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("setwins_cleared", {31'd0, overflow}, 32'd0);

        // Edge at full with a simultaneous take
        tgl_in = ~tgl_in;
        tick(LAT - 1);
        evt_if.evt_ready = 1'b1;
        tick(1);
        evt_if.evt_ready = 1'b0;
        check("fulltake_pulse",    {31'd0, evt_pulse}, 32'd1);
        check("fulltake_pending",  {28'd0, pending}, 32'd15);
        check("fulltake_overflow", {31'd0, overflow}, 32'd0);
        check("fulltake_count",    {24'd0, evt_count}, 32'd3);

        // Drain to 3, then asynchronous reset mid-cycle
        evt_if.evt_ready = 1'b1;
        tick(12);
        evt_if.evt_ready = 1'b0;
        check("pre_rst_pending", {28'd0, pending}, 32'd3);
        check("pre_rst_count",   {24'd0, evt_count}, 32'd15);
        #2;
        rst_n  = 1'b0;
        tgl_in = 1'b0;
        #1;
        check("async_pending",  {28'd0, pending}, 32'd0);
        check("async_valid",    {31'd0, evt_if.evt_valid}, 32'd0);
        check("async_count",    {24'd0, evt_count}, 32'd0);
        check("async_overflow", {31'd0, overflow}, 32'd0);
        tick(2);
        rst_n = 1'b1;
        pulses = 0;
        tick(10);
        check("post_rst_pulses",  pulses, 32'd0);
        check("post_rst_pending", {28'd0, pending}, 32'd0);

        // Delivered-count wrap at 2^8
        evt_if.evt_ready = 1'b1;
        for (int i = 0; i < 255; i++) begin
            tgl_in = ~tgl_in;
            tick(4);
        end
        tick(3);
        check("wrap255_count",   {24'd0, evt_count}, 32'd255);
        check("wrap255_pending", {28'd0, pending}, 32'd0);
        tgl_in = ~tgl_in;
        tick(LAT + 2);
        check("wrap0_count", {24'd0, evt_count}, 32'd0);
        check("wrap0_valid", {31'd0, evt_if.evt_valid}, 32'd0);
        evt_if.evt_ready = 1'b0;
        tick(4);

`ifdef TGL_DEGLITCH_EN
        // One-cycle glitch on the synchronised level is ignored
        pulses = 0;
        tgl_in = ~tgl_in;
        tick(1);
        tgl_in = ~tgl_in;
        tick(8);
        check("glitch_pulses",  pulses, 32'd0);
        check("glitch_pending", {28'd0, pending}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
